// File: rtl/sqrt_prenorm_fsm.sv
// Operand front-end for the sqrt / inverse-sqrt unit: classify, normalize, split exponent parity, start the core.
// Define SQRT_PRENORM_DENORM_EN to normalize denormals in NORM; otherwise denormals flush to signed zero.
module sqrt_prenorm_fsm #(
  parameter int E_DW = 8,
  parameter int F_DW = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     op_valid_i,
  output logic                     op_ready_o,
  input  logic [E_DW+F_DW:0]       op_i,
  input  logic                     do_inv_i,
  input  logic                     core_valid_i,
  output logic                     DoSqrt_o,
  output logic                     DoInvSqrt_o,
  output logic [F_DW+1:0]          m_o,
  output logic [E_DW:0]            exp_o,
  output logic                     spec_valid_o,
  output logic [E_DW+F_DW:0]       spec_res_o,
  output logic                     flag_nv_o,
  output logic                     flag_dz_o
);

  localparam int OP_W = 1 + E_DW + F_DW;
  // Unbiased exponent needs two extra bits to reach below the denormal floor.
  localparam int EW   = E_DW + 2;
  localparam int BIAS = (1 << (E_DW - 1)) - 1;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
`ifdef SQRT_PRENORM_DENORM_EN
    NORM,
`endif
    ISSUE,
    WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [OP_W-1:0]        op_q, op_d;
  logic                   inv_q, inv_d;
  logic [F_DW:0]          sig_q, sig_d;
  logic signed [EW-1:0]   e_q, e_d;

  logic                   sign_w;
  logic [E_DW-1:0]        exp_w;
  logic [F_DW-1:0]        frac_w;
  logic                   exp_all1, exp_zero, frac_zero;
  logic                   is_nan, is_inf, is_zero, is_neg_nz, is_special;
  logic [OP_W-1:0]        qnan;
  logic [OP_W-1:0]        spec_res_w;
  logic                   spec_nv_w, spec_dz_w;
  logic [E_DW:0]          k_w;

  assign sign_w    = op_q[OP_W-1];
  assign exp_w     = op_q[OP_W-2:F_DW];
  assign frac_w    = op_q[F_DW-1:0];
  assign exp_all1  = &exp_w;
  assign exp_zero  = ~|exp_w;
  assign frac_zero = ~|frac_w;
  assign is_nan    = exp_all1 & ~frac_zero;
  assign is_inf    = exp_all1 & frac_zero;
`ifdef SQRT_PRENORM_DENORM_EN
  assign is_zero   = exp_zero & frac_zero;
`else
  assign is_zero   = exp_zero;
`endif
  assign is_neg_nz  = sign_w & ~is_zero & ~is_nan;
  assign is_special = is_nan | is_inf | is_zero | is_neg_nz;
  assign qnan       = {1'b0, {E_DW{1'b1}}, 1'b1, {(F_DW-1){1'b0}}};

  // Special-result table; NaN input wins over the sign check so -NaN raises no flag.
  always_comb begin
    spec_res_w = '0;
    spec_nv_w  = 1'b0;
    spec_dz_w  = 1'b0;
    if (is_nan) begin
      spec_res_w = qnan;
    end else if (is_zero) begin
      if (inv_q) begin
        spec_res_w = {sign_w, {E_DW{1'b1}}, {F_DW{1'b0}}};
        spec_dz_w  = 1'b1;
      end else begin
        spec_res_w = {sign_w, {(OP_W-1){1'b0}}};
      end
    end else if (is_neg_nz) begin
      spec_res_w = qnan;
      spec_nv_w  = 1'b1;
    end else if (is_inf) begin
      spec_res_w = inv_q ? '0 : {1'b0, {E_DW{1'b1}}, {F_DW{1'b0}}};
    end
  end

  // k = e/2 for even e, (e+1)/2 for odd e: arithmetic half plus the parity bit.
  assign k_w = e_q[EW-1:1] + {{E_DW{1'b0}}, e_q[0]};

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    inv_d        = inv_q;
    sig_d        = sig_q;
    e_d          = e_q;
    op_ready_o   = 1'b0;
    DoSqrt_o     = 1'b0;
    DoInvSqrt_o  = 1'b0;
    m_o          = '0;
    exp_o        = '0;
    spec_valid_o = 1'b0;
    spec_res_o   = '0;
    flag_nv_o    = 1'b0;
    flag_dz_o    = 1'b0;

    case (state_q)
      IDLE: begin
        op_ready_o = rst;
        if (op_valid_i) begin
          op_d    = op_i;
          inv_d   = do_inv_i;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (is_special) begin
          spec_valid_o = 1'b1;
          spec_res_o   = spec_res_w;
          flag_nv_o    = spec_nv_w;
          flag_dz_o    = spec_dz_w;
          state_d      = IDLE;
`ifdef SQRT_PRENORM_DENORM_EN
        end else if (exp_zero) begin
          sig_d   = {1'b0, frac_w};
          e_d     = EW'(1 - BIAS);
          state_d = NORM;
`endif
        end else begin
          sig_d   = {1'b1, frac_w};
          e_d     = {2'b00, exp_w} - EW'(BIAS);
          state_d = ISSUE;
        end
      end
`ifdef SQRT_PRENORM_DENORM_EN
      NORM: begin
        sig_d = sig_q << 1;
        e_d   = e_q - EW'(1);
        if (sig_q[F_DW-1]) begin
          state_d = ISSUE;
        end
      end
`endif
      ISSUE: begin
        DoSqrt_o    = ~inv_q;
        DoInvSqrt_o = inv_q;
        m_o         = e_q[0] ? {1'b0, sig_q} : {sig_q, 1'b0};
        exp_o       = inv_q ? -k_w : k_w;
        state_d     = WAIT;
      end
      WAIT: begin
        m_o   = e_q[0] ? {1'b0, sig_q} : {sig_q, 1'b0};
        exp_o = inv_q ? -k_w : k_w;
        if (core_valid_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      inv_q   <= 1'b0;
      sig_q   <= '0;
      e_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      inv_q   <= inv_d;
      sig_q   <= sig_d;
      e_q     <= e_d;
    end
  end

endmodule

// File: tb/tb_sqrt_prenorm_fsm.sv
// Bench for sqrt_prenorm_fsm: vector table, randomized operands against a value-level model, corner sequences.
module tb_sqrt_prenorm_fsm;

`ifdef SQRT_PRENORM_DENORM_EN
  localparam bit DENORM = 1'b1;
`else
  localparam bit DENORM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid_i, op_ready_o, do_inv_i, core_valid_i;
  logic [15:0] op_i;
  logic        DoSqrt_o, DoInvSqrt_o;
  logic [8:0]  m_o;
  logic [8:0]  exp_o;
  logic        spec_valid_o;
  logic [15:0] spec_res_o;
  logic        flag_nv_o, flag_dz_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sqrt_prenorm_fsm dut (
    .clk(clk), .rst(rst),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .op_i(op_i), .do_inv_i(do_inv_i), .core_valid_i(core_valid_i),
    .DoSqrt_o(DoSqrt_o), .DoInvSqrt_o(DoInvSqrt_o),
    .m_o(m_o), .exp_o(exp_o),
    .spec_valid_o(spec_valid_o), .spec_res_o(spec_res_o),
    .flag_nv_o(flag_nv_o), .flag_dz_o(flag_dz_o)
  );

  typedef struct {
    logic [15:0] op;
    bit          inv;
    bit          spec;
    logic [15:0] res;
    bit          nv;
    bit          dz;
    logic [8:0]  m;
    logic [8:0]  ex;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  function automatic vec_t mk(input logic [15:0] op, input bit inv, input bit spec,
                              input logic [15:0] res, input bit nv, input bit dz,
                              input logic [8:0] m, input logic [8:0] ex, input int lat);
    vec_t v;
    v.op = op; v.inv = inv; v.spec = spec; v.res = res; v.nv = nv; v.dz = dz;
    v.m = m; v.ex = ex; v.lat = lat;
    return v;
  endfunction

  // Value-level reference: decode the float, normalize by doubling, halve the exponent.
  function automatic vec_t model(input logic [15:0] op, input bit inv);
    vec_t v;
    int s, bexp, f, e, n, k;
    logic [8:0] k9;
    s = int'(op[15]); bexp = int'(op[14:7]); f = int'(op[6:0]);
    v = mk(op, inv, 1'b0, 16'h0, 1'b0, 1'b0, 9'h0, 9'h0, 2);
    if (bexp == 255 && f != 0) begin
      v.spec = 1; v.res = 16'h7FC0;
    end else if (bexp == 0 && (f == 0 || !DENORM)) begin
      v.spec = 1;
      if (inv) begin v.res = (s != 0) ? 16'hFF80 : 16'h7F80; v.dz = 1; end
      else v.res = (s != 0) ? 16'h8000 : 16'h0000;
    end else if (s != 0) begin
      v.spec = 1; v.res = 16'h7FC0; v.nv = 1;
    end else if (bexp == 255) begin
      v.spec = 1; v.res = inv ? 16'h0000 : 16'h7F80;
    end else begin
      n = 0;
      if (bexp == 0) begin
        while (f < 128) begin f = f * 2; n++; end
        f = f - 128;
        e = -126 - n;
      end else begin
        e = bexp - 127;
      end
      v.lat = 2 + n;
      if (e % 2 == 0) begin k = e / 2; v.m = 9'(256 + 2 * f); end
      else begin k = (e + 1) / 2; v.m = 9'(128 + f); end
      if (inv) k = -k;
      k9 = 9'(k);
      v.ex = k9;
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int delay, input string tag);
    int cyc;
    @(negedge clk);
    chk({tag, " ready_idle"}, 32'(op_ready_o), 32'd1);
    op_valid_i = 1'b1; op_i = v.op; do_inv_i = v.inv;
    @(negedge clk);
    op_valid_i = 1'b0;
    chk({tag, " spec_valid"}, 32'(spec_valid_o), 32'(v.spec));
    if (v.spec) begin
      chk({tag, " spec_res"}, 32'(spec_res_o), 32'(v.res));
      chk({tag, " nv_dz"}, 32'({flag_nv_o, flag_dz_o}), 32'({v.nv, v.dz}));
      chk({tag, " no_start"}, 32'({DoSqrt_o, DoInvSqrt_o}), 32'd0);
      @(negedge clk);
      chk({tag, " ready_after_spec"}, 32'(op_ready_o), 32'd1);
    end else begin
      cyc = 1;
      while (!(DoSqrt_o || DoInvSqrt_o) && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      chk({tag, " start_cycle"}, 32'(cyc), 32'(v.lat));
      chk({tag, " start_kind"}, 32'({DoSqrt_o, DoInvSqrt_o}), 32'({~v.inv, v.inv}));
      chk({tag, " m_o"}, 32'(m_o), 32'(v.m));
      chk({tag, " exp_o"}, 32'(exp_o), 32'(v.ex));
      @(negedge clk);
      chk({tag, " pulse_one_cycle"}, 32'({DoSqrt_o, DoInvSqrt_o}), 32'd0);
      for (int i = 0; i < delay; i++) @(negedge clk);
      chk({tag, " wait_hold"}, 32'({op_ready_o, m_o, exp_o}), 32'({1'b0, v.m, v.ex}));
      core_valid_i = 1'b1;
      @(negedge clk);
      core_valid_i = 1'b0;
      chk({tag, " ready_after_core"}, 32'(op_ready_o), 32'd1);
    end
  endtask

  vec_t tbl[14];
  vec_t rv;
  logic [15:0] rop;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(16'h4080, 0, 0, 16'h0,    0, 0, 9'h100, 9'h001, 2);
    tbl[1]  = mk(16'h4000, 0, 0, 16'h0,    0, 0, 9'h080, 9'h001, 2);
    tbl[2]  = mk(16'h4000, 1, 0, 16'h0,    0, 0, 9'h080, 9'h1FF, 2);
    tbl[3]  = mk(16'h8000, 1, 1, 16'hFF80, 0, 1, 9'h0,   9'h0,   2);
    tbl[4]  = mk(16'hBF80, 0, 1, 16'h7FC0, 1, 0, 9'h0,   9'h0,   2);
    if (DENORM) tbl[5] = mk(16'h0001, 0, 0, 16'h0, 0, 0, 9'h080, 9'h1BE, 9);
    else        tbl[5] = mk(16'h0001, 0, 1, 16'h0000, 0, 0, 9'h0, 9'h0, 2);
    tbl[6]  = mk(16'h7F80, 0, 1, 16'h7F80, 0, 0, 9'h0,   9'h0,   2);
    tbl[7]  = mk(16'h7F80, 1, 1, 16'h0000, 0, 0, 9'h0,   9'h0,   2);
    tbl[8]  = mk(16'h7FC1, 1, 1, 16'h7FC0, 0, 0, 9'h0,   9'h0,   2);
    tbl[9]  = mk(16'h0000, 0, 1, 16'h0000, 0, 0, 9'h0,   9'h0,   2);
    tbl[10] = mk(16'h3F80, 1, 0, 16'h0,    0, 0, 9'h100, 9'h000, 2);
    tbl[11] = mk(16'h7F7F, 0, 0, 16'h0,    0, 0, 9'h0FF, 9'h040, 2);
    tbl[12] = mk(16'h7F7F, 1, 0, 16'h0,    0, 0, 9'h0FF, 9'h1C0, 2);
    tbl[13] = mk(16'hFF80, 0, 1, 16'h7FC0, 1, 0, 9'h0,   9'h0,   2);

    rst = 1'b0; op_valid_i = 1'b0; op_i = '0; do_inv_i = 1'b0; core_valid_i = 1'b0;
    #23;
    chk("reset_outputs", 32'({op_ready_o, DoSqrt_o, DoInvSqrt_o, m_o, exp_o, spec_valid_o,
                               spec_res_o[4:0], flag_nv_o, flag_dz_o}), 32'd0);
    chk("reset_spec_res", 32'(spec_res_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ready_after_release", 32'(op_ready_o), 32'd1);

    for (int i = 0; i < 14; i++) run_vec(tbl[i], i % 4, $sformatf("tbl%0d", i));

    // Spurious core valid in IDLE must be ignored.
    @(negedge clk);
    core_valid_i = 1'b1;
    @(negedge clk);
    core_valid_i = 1'b0;
    chk("spurious_core_valid", 32'({op_ready_o, DoSqrt_o, DoInvSqrt_o, spec_valid_o, m_o}),
        32'({1'b1, 12'h0}));
    run_vec(tbl[0], 1, "after_spurious");

    // New operand held valid during WAIT: not captured until after core valid.
    @(negedge clk);
    op_valid_i = 1'b1; op_i = 16'h4080; do_inv_i = 1'b0;
    @(negedge clk);
    op_valid_i = 1'b0;
    @(negedge clk);
    chk("hold_first_start", 32'(DoSqrt_o), 32'd1);
    op_valid_i = 1'b1; op_i = 16'h4000; do_inv_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_wait_no_capture", 32'({op_ready_o, m_o, exp_o}), 32'({1'b0, 9'h100, 9'h001}));
    end
    core_valid_i = 1'b1;
    @(negedge clk);
    core_valid_i = 1'b0;
    chk("hold_ready_after_core", 32'(op_ready_o), 32'd1);
    @(negedge clk);
    op_valid_i = 1'b0;
    chk("hold_second_decode", 32'({op_ready_o, spec_valid_o, DoInvSqrt_o}), 32'd0);
    @(negedge clk);
    chk("hold_second_start", 32'({DoSqrt_o, DoInvSqrt_o, m_o, exp_o}),
        32'({2'b01, 9'h080, 9'h1FF}));
    @(negedge clk);
    core_valid_i = 1'b1;
    @(negedge clk);
    core_valid_i = 1'b0;

    // Reset asserted in WAIT drops everything at once.
    @(negedge clk);
    op_valid_i = 1'b1; op_i = 16'h4080; do_inv_i = 1'b0;
    @(negedge clk);
    op_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_wait", 32'({op_ready_o, m_o}), 32'({1'b0, 9'h100}));
    rst = 1'b0;
    #1;
    chk("mid_wait_reset", 32'({op_ready_o, DoSqrt_o, DoInvSqrt_o, m_o, exp_o, spec_valid_o,
                                flag_nv_o, flag_dz_o}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_vec(tbl[0], 2, "after_reset");

    for (int i = 0; i < 60; i++) begin
      rop = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rop[14:7] = 8'h00;
        1: rop[14:7] = 8'hFF;
        default: ;
      endcase
      rv = model(rop, 1'($urandom_range(0, 1)));
      run_vec(rv, $urandom_range(0, 6), $sformatf("rnd%0d_%h", i, rop));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
